multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. Sequences each instruction through
//  fetch/decode/execute/memory/writeback, produces every datapath enable and mux select,
//  and drives aluOp_out, the 2-bit code that alu_control decodes together with funct.
//  Sits between the instruction register (opcode) and the datapath/alu_control.
// PARAMETERS
//  (none): widths are fixed by the ISA; encodings come from mips_pkg
// PORTS
//  clk_in        in   1  single clock, rising edge
//  reset_in      in   1  asynchronous, active-high reset
//  opcode_in     in   6  IR[31:26], valid from DECODE onward
//  zero_in       in   1  ALU zero flag (branch compare)
//  memReady_in   in   1  memory completes the current access this cycle
//  pcEn_out      out  1  PC write enable = pcWrite | (pcWriteCond & zero_in)
//  iorD_out      out  1  0: address=PC, 1: address=ALUOut
//  memRead_out   out  1  memory read request
//  memWrite_out  out  1  memory write request
//  irWrite_out   out  1  load IR
//  regDst_out    out  1  0: rt, 1: rd
//  memToReg_out  out  1  0: ALUOut, 1: MDR
//  regWrite_out  out  1  register-file write enable
//  aluSrcA_out   out  1  0: PC, 1: A
//  aluSrcB_out   out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
//  aluOp_out     out  2  00 add, 01 sub, 10 use funct; 11 never driven
//  pcSource_out  out  2  00 ALU result, 01 ALUOut, 10 jump target
//  illegal_out   out  1  one-cycle pulse: undefined opcode seen in DECODE
//  state_out     out  4  current state encoding (debug/verification)
// BEHAVIOUR
//  Reset: async to FETCH; while reset_in=1 every output is 0, including state_out.
//  Outputs are a combinational decode of state; unlisted outputs are 0 in every state.
//  Exception: pcEn_out, irWrite_out in FETCH and the state advance also depend on memReady_in.
//  States and transitions (encoding 0..11):
//   FETCH(0)    memRead, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00;
//               irWrite=pcWrite=memReady_in; ->DECODE on memReady_in, else stay.
//   DECODE(1)   aluSrcA=0, aluSrcB=11, aluOp=00 (branch target into ALUOut);
//               opcode 100011/101011 ->MEMADR, 000000 ->EXECUTE, 000100 ->BRANCH,
//               000010 ->JUMP, 001000 ->ADDIEXEC, other ->FETCH with illegal_out=1.
//   MEMADR(2)   aluSrcA=1, aluSrcB=10, aluOp=00; lw ->MEMREAD, sw ->MEMWRITE.
//   MEMREAD(3)  memRead, iorD=1; ->MEMWB on memReady_in, else stay.
//   MEMWB(4)    regWrite, regDst=0, memToReg=1; ->FETCH.
//   MEMWRITE(5) memWrite, iorD=1; ->FETCH on memReady_in, else stay.
//   EXECUTE(6)  aluSrcA=1, aluSrcB=00, aluOp=10; ->ALUWB.
//   ALUWB(7)    regWrite, regDst=1, memToReg=0; ->FETCH.
//   BRANCH(8)   aluSrcA=1, aluSrcB=00, aluOp=01, pcSource=01, pcWriteCond; ->FETCH.
//   ADDIEXEC(9) aluSrcA=1, aluSrcB=10, aluOp=00; ->ADDIWB.
//   ADDIWB(10)  regWrite, regDst=0, memToReg=0; ->FETCH.
//   JUMP(11)    pcSource=10, pcWrite; ->FETCH.
//  Latency with memReady_in always 1: lw 5, sw/R/addi 4, beq/j 3 cycles.
//  opcode_in is sampled in DECODE and MEMADR only. IR is stable, so no opcode register.
//  Unused encodings 12..15 -> FETCH next cycle, all outputs 0 (never reached after reset).
//  Reset mid-access drops memRead/memWrite immediately. No partial write is committed.
// STRUCTURE
//  mips_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI),
//   aluOp constants (ALUOP_ADD/SUB/FUNCT), state_t enum (4-bit, values above).
//  Sub-module control_output_decode: combinational state(+memReady,zero) -> outputs.
//  Top holds the state register and next-state logic.
// TESTING
//  lw, memReady=1: states 0,1,2,3,4,0; MEMADR aluOp=00 aluSrcB=10; MEMWB memToReg=1 regWrite=1.
//  R-type 000000: EXECUTE aluOp=10 aluSrcB=00; ALUWB regDst=1 regWrite=1; back to FETCH.
//  beq, zero_in=1 in BRANCH: aluOp=01 pcSource=01 pcEn=1. Repeat with zero_in=0: pcEn=0.
//  FETCH with memReady=0 for 3 cycles then 1: memRead held 4 cycles; irWrite and pcEn only on cycle 4.
//  reset_in=1 during MEMWRITE (memReady=0): all outputs 0 at once; after release state_out=0, memRead=1.
//  opcode 111111: DECODE pulses illegal_out=1 for 1 cycle, then FETCH; j 000010: pcSource=10 pcEn=1.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU operation
// codes, mux selects, the controller state enum and the bundled control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcEn;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
    } ctrl_t;

    function automatic logic isLegalOpcode(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational decode of the controller state into every datapath enable and
// mux select; only FETCH and BRANCH look at memReady/zero.
module control_output_decode
    import mips_pkg::*;
(
    input  logic   hold,
    input  state_t state,
    input  logic   memReady,
    input  logic   zero,
    output ctrl_t  ctrl
);

    logic pcWrite;
    logic pcWriteCond;

    // Every field starts at 0 so each state lists only what it asserts; hold
    // forces the whole word low so reset kills any in-flight memory request.
    always_comb begin
        ctrl        = '0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        case (state)
            FETCH: begin
                ctrl.memRead = 1'b1;
                ctrl.aluSrcB = SRCB_FOUR;
                ctrl.aluOp   = ALUOP_ADD;
                ctrl.irWrite = memReady;
                pcWrite      = memReady;
            end
            DECODE: begin
                ctrl.aluSrcB = SRCB_IMMSH2;
                ctrl.aluOp   = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            MEMREAD: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            MEMWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = 1'b1;
            end
            MEMWRITE: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            EXECUTE: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_REG;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
            end
            BRANCH: begin
                ctrl.aluSrcA  = 1'b1;
                ctrl.aluSrcB  = SRCB_REG;
                ctrl.aluOp    = ALUOP_SUB;
                ctrl.pcSource = PCSRC_ALUOUT;
                pcWriteCond   = 1'b1;
            end
            ADDIEXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            ADDIWB: begin
                ctrl.regWrite = 1'b1;
            end
            JUMP: begin
                ctrl.pcSource = PCSRC_JUMP;
                pcWrite       = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
        ctrl.pcEn = pcWrite | (pcWriteCond & zero);
        if (hold) begin
            ctrl = '0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: holds the state register and
// next-state logic, and exposes the decoded control word on individual ports.
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic [5:0] opcode_in,
    input  logic       zero_in,
    input  logic       memReady_in,
    output logic       pcEn_out,
    output logic       iorD_out,
    output logic       memRead_out,
    output logic       memWrite_out,
    output logic       irWrite_out,
    output logic       regDst_out,
    output logic       memToReg_out,
    output logic       regWrite_out,
    output logic       aluSrcA_out,
    output logic [1:0] aluSrcB_out,
    output logic [1:0] aluOp_out,
    output logic [1:0] pcSource_out,
    output logic       illegal_out,
    output logic [3:0] state_out
);

    state_t state;
    state_t nextState;
    logic   illegalSeen;
    ctrl_t  ctrl;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Memory states wait on memReady; the opcode is read straight from the IR
    // in DECODE and MEMADR because it stays stable for the whole instruction.
    always_comb begin
        nextState   = state;
        illegalSeen = 1'b0;
        case (state)
            FETCH: begin
                if (memReady_in) begin
                    nextState = DECODE;
                end
            end
            DECODE: begin
                case (opcode_in)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = EXECUTE;
                    OP_BEQ:       nextState = BRANCH;
                    OP_J:         nextState = JUMP;
                    OP_ADDI:      nextState = ADDIEXEC;
                    default: begin
                        nextState   = FETCH;
                        illegalSeen = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                nextState = (opcode_in == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                if (memReady_in) begin
                    nextState = MEMWB;
                end
            end
            MEMWB:    nextState = FETCH;
            MEMWRITE: begin
                if (memReady_in) begin
                    nextState = FETCH;
                end
            end
            EXECUTE:  nextState = ALUWB;
            ALUWB:    nextState = FETCH;
            BRANCH:   nextState = FETCH;
            ADDIEXEC: nextState = ADDIWB;
            ADDIWB:   nextState = FETCH;
            JUMP:     nextState = FETCH;
            default:  nextState = FETCH;
        endcase
    end

    control_output_decode outputDecode (
        .hold     (reset_in),
        .state    (state),
        .memReady (memReady_in),
        .zero     (zero_in),
        .ctrl     (ctrl)
    );

    assign pcEn_out     = ctrl.pcEn;
    assign iorD_out     = ctrl.iorD;
    assign memRead_out  = ctrl.memRead;
    assign memWrite_out = ctrl.memWrite;
    assign irWrite_out  = ctrl.irWrite;
    assign regDst_out   = ctrl.regDst;
    assign memToReg_out = ctrl.memToReg;
    assign regWrite_out = ctrl.regWrite;
    assign aluSrcA_out  = ctrl.aluSrcA;
    assign aluSrcB_out  = ctrl.aluSrcB;
    assign aluOp_out    = ctrl.aluOp;
    assign pcSource_out = ctrl.pcSource;
    assign illegal_out  = illegalSeen & ~reset_in;
    assign state_out    = reset_in ? 4'd0 : 4'(state);

endmodule
